// File: rtl/lcd_instruction_executor_if.sv
// Handshake and pin bundle between a message-sequencing FSM and the LCD write executor.
// Latency: none; the interface only groups signals.
// Backpressure: LCD_busy high means LCD_start is ignored. Requests are not queued.
//
// Signals:
//   LCD_start, LCD_instruction         request from the sequencer (bit 8 = RS, bits 7:0 = bus byte)
//   LCD_done, LCD_busy                 completion pulse and busy status back to the sequencer
//   LCD_power, LCD_back_light,
//   LCD_read_write, LCD_enable,
//   LCD_command_data_select,
//   LCD_data_io                        HD44780-style pin drives
// Modports:
//   master  the sequencer side; it also observes the pins
//   slave   the executor side
interface lcd_instruction_executor_if;
  logic       LCD_start;
  logic [8:0] LCD_instruction;
  logic       LCD_done;
  logic       LCD_busy;
  logic       LCD_power;
  logic       LCD_back_light;
  logic       LCD_read_write;
  logic       LCD_enable;
  logic       LCD_command_data_select;
  logic [7:0] LCD_data_io;

  modport master (
    output LCD_start,
    output LCD_instruction,
    input  LCD_done,
    input  LCD_busy,
    input  LCD_power,
    input  LCD_back_light,
    input  LCD_read_write,
    input  LCD_enable,
    input  LCD_command_data_select,
    input  LCD_data_io
  );

  modport slave (
    input  LCD_start,
    input  LCD_instruction,
    output LCD_done,
    output LCD_busy,
    output LCD_power,
    output LCD_back_light,
    output LCD_read_write,
    output LCD_enable,
    output LCD_command_data_select,
    output LCD_data_io
  );
endinterface

// File: rtl/lcd_instruction_executor.sv
// Executes one 9-bit LCD instruction per start pulse on a write-only HD44780-style bus.
// Latency: done pulses SETUP+EN_HIGH+HOLD+delay cycles after acceptance. The delay is long for clear/home, short otherwise.
// Backpressure: LCD_busy is high from acceptance until the done cycle, and LCD_start is ignored while busy.
//
// Ports:
//   Clock_50  system clock (50 MHz)
//   Reset     asynchronous active-high reset
//   lcd       lcd_instruction_executor_if.slave: start/instruction in; done/busy and LCD pins out
module lcd_instruction_executor #(
  parameter int SETUP_CYCLES   = 4,
  parameter int EN_HIGH_CYCLES = 12,
  parameter int HOLD_CYCLES    = 4,
  parameter int SHORT_DELAY    = 2000,
  parameter int LONG_DELAY     = 80000,
  parameter int DELAY_WIDTH    = 18
) (
  input  logic                          Clock_50,
  input  logic                          Reset,
  lcd_instruction_executor_if.slave     lcd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ENABLE,
    S_HOLD,
    S_DELAY
  } state_t;

  // The counter is loaded with (length - 1) on entry to a phase. The phase ends on
  // the edge where the counter is already zero, so each phase lasts exactly
  // 'length' cycles.
  localparam logic [DELAY_WIDTH-1:0] SETUP_LOAD = DELAY_WIDTH'(SETUP_CYCLES - 1);
  localparam logic [DELAY_WIDTH-1:0] EN_LOAD    = DELAY_WIDTH'(EN_HIGH_CYCLES - 1);
  localparam logic [DELAY_WIDTH-1:0] HOLD_LOAD  = DELAY_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [DELAY_WIDTH-1:0] SHORT_LOAD = DELAY_WIDTH'(SHORT_DELAY - 1);
  localparam logic [DELAY_WIDTH-1:0] LONG_LOAD  = DELAY_WIDTH'(LONG_DELAY - 1);
  localparam logic [DELAY_WIDTH-1:0] CNT_ONE    = DELAY_WIDTH'(1);

  state_t                 state_q,  state_nxt;
  logic [DELAY_WIDTH-1:0] cnt_q,    cnt_nxt;
  logic [DELAY_WIDTH-1:0] delay_q,  delay_nxt;   // execution delay chosen at acceptance
  logic                   rs_q,     rs_nxt;
  logic [7:0]             data_q,   data_nxt;
  logic                   en_q,     en_nxt;
  logic                   done_q,   done_nxt;
  logic                   busy_q,   busy_nxt;
  logic                   power_q;
  logic                   cnt_zero;
  logic                   is_long_cmd;

  assign cnt_zero = (cnt_q == '0);

  // Clear (01) and return-home (02/03) need the long execution time.
  assign is_long_cmd = !lcd.LCD_instruction[8]
                    && (lcd.LCD_instruction[7:2] == 6'd0)
                    && (lcd.LCD_instruction[1:0] != 2'd0);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    delay_nxt = delay_q;
    rs_nxt    = rs_q;
    data_nxt  = data_q;
    done_nxt  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Being in S_IDLE is the same as LCD_busy being low, so this is also
        // where a start in the done cycle of a previous instruction is accepted.
        if (lcd.LCD_start) begin
          state_nxt = S_SETUP;
          cnt_nxt   = SETUP_LOAD;
          rs_nxt    = lcd.LCD_instruction[8];
          data_nxt  = lcd.LCD_instruction[7:0];
          delay_nxt = is_long_cmd ? LONG_LOAD : SHORT_LOAD;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_nxt = S_ENABLE;
          cnt_nxt   = EN_LOAD;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end
      S_ENABLE: begin
        if (cnt_zero) begin
          state_nxt = S_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          state_nxt = S_DELAY;
          cnt_nxt   = delay_q;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end
      S_DELAY: begin
        if (cnt_zero) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // EN and busy are registered copies of the next state. They change on the
    // same edge as the state, with no extra cycle of lag.
    en_nxt   = (state_nxt == S_ENABLE);
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      power_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      delay_q <= delay_nxt;
      rs_q    <= rs_nxt;
      data_q  <= data_nxt;
      en_q    <= en_nxt;
      done_q  <= done_nxt;
      busy_q  <= busy_nxt;
      power_q <= 1'b1;
    end
  end

  assign lcd.LCD_done                = done_q;
  assign lcd.LCD_busy                = busy_q;
  assign lcd.LCD_power               = power_q;
  assign lcd.LCD_back_light          = power_q;
  assign lcd.LCD_read_write          = 1'b0;   // write-only bus
  assign lcd.LCD_enable              = en_q;
  assign lcd.LCD_command_data_select = rs_q;
  assign lcd.LCD_data_io             = data_q;

endmodule

// File: tb/tb_lcd_instruction_executor.sv
// Scoreboard bench for lcd_instruction_executor with shortened execution delays.
// Latency: one expected transaction is queued per accepted start edge and checked cycle by cycle.
// Backpressure: the reference model drops starts that land while a transaction is in flight.
module tb_lcd_instruction_executor;

  localparam int S  = 4;
  localparam int E  = 12;
  localparam int H  = 4;
  localparam int SD = 40;
  localparam int LD = 150;
  localparam int DW = 18;

  logic Clock_50 = 1'b0;
  logic Reset    = 1'b1;

  lcd_instruction_executor_if lcd_bus();

  lcd_instruction_executor #(
    .SETUP_CYCLES   (S),
    .EN_HIGH_CYCLES (E),
    .HOLD_CYCLES    (H),
    .SHORT_DELAY    (SD),
    .LONG_DELAY     (LD),
    .DELAY_WIDTH    (DW)
  ) dut (
    .Clock_50 (Clock_50),
    .Reset    (Reset),
    .lcd      (lcd_bus)
  );

  initial forever #5 Clock_50 = ~Clock_50;

  typedef struct {
    int         acc;    // edge at which the start is accepted
    int         done;   // edge at which done pulses
    logic       rs;
    logic [7:0] dat;
  } txn_t;

  txn_t       sb[$];
  int         total     = 0;
  int         bad       = 0;
  int         cyc       = 0;
  int         since_rst = 0;
  int         free_edge = 0;
  int         last_done = 0;
  logic       hold_rs   = 1'b0;
  logic [7:0] hold_dat  = 8'h00;

  always @(posedge Clock_50) cyc <= cyc + 1;

  always @(posedge Clock_50 or posedge Reset)
    if (Reset) since_rst <= 0;
    else       since_rst <= since_rst + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a start seen at edge n is taken unless an earlier
  // instruction is still busy. Busy ends at its done edge, so n must be past it.
  task automatic model_edge(input int n, input logic [8:0] ins);
    txn_t t;
    int   d;
    if (n >= free_edge) begin
      d = (ins[8] == 1'b0 && ins[7:0] >= 8'd1 && ins[7:0] <= 8'd3) ? LD : SD;
      t.acc  = n;
      t.done = n + S + E + H + d;
      t.rs   = ins[8];
      t.dat  = ins[7:0];
      sb.push_back(t);
      free_edge = t.done + 1;
      last_done = t.done;
    end
  endtask

  task automatic step();
    @(posedge Clock_50);
    #1;
  endtask

  // Called just after an edge. Start is held for n edges, beginning with the next one.
  task automatic send(input logic [8:0] ins, input int n);
    lcd_bus.LCD_start       = 1'b1;
    lcd_bus.LCD_instruction = ins;
    for (int i = 0; i < n; i++) begin
      model_edge(cyc + 1, ins);
      step();
    end
    lcd_bus.LCD_start       = 1'b0;
    lcd_bus.LCD_instruction = 9'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sb.size() > 0 && k < 4 * LD) begin
      step();
      k++;
    end
    total++;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain timeout: pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic hit_reset();
    Reset             = 1'b1;
    lcd_bus.LCD_start = 1'b0;
    sb.delete();
    free_edge = 0;
    hold_rs   = 1'b0;
    hold_dat  = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en"},    lcd_bus.LCD_enable, 0);
    chk({tag, "_busy"},  lcd_bus.LCD_busy, 0);
    chk({tag, "_done"},  lcd_bus.LCD_done, 0);
    chk({tag, "_power"}, lcd_bus.LCD_power, 0);
    chk({tag, "_bl"},    lcd_bus.LCD_back_light, 0);
    chk({tag, "_rs"},    lcd_bus.LCD_command_data_select, 0);
    chk({tag, "_data"},  lcd_bus.LCD_data_io, 0);
  endtask

  // Monitor: compares every pin against the scoreboard head on the falling edge.
  always @(negedge Clock_50) begin : mon
    logic       have, eb, ee, ed, ers;
    logic [7:0] edat;
    if (!Reset) begin
      have = (sb.size() > 0);
      eb   = have && cyc >= sb[0].acc && cyc < sb[0].done;
      ee   = have && cyc >= sb[0].acc + S && cyc < sb[0].acc + S + E;
      ed   = have && cyc == sb[0].done;
      ers  = (have && cyc >= sb[0].acc) ? sb[0].rs  : hold_rs;
      edat = (have && cyc >= sb[0].acc) ? sb[0].dat : hold_dat;
      chk("busy",       lcd_bus.LCD_busy, eb);
      chk("enable",     lcd_bus.LCD_enable, ee);
      chk("done",       lcd_bus.LCD_done, ed);
      chk("rs",         lcd_bus.LCD_command_data_select, ers);
      chk("data",       lcd_bus.LCD_data_io, edat);
      chk("read_write", lcd_bus.LCD_read_write, 0);
      chk("power",      lcd_bus.LCD_power, since_rst >= 1);
      chk("back_light", lcd_bus.LCD_back_light, since_rst >= 1);
      if (have && cyc >= sb[0].done) begin
        hold_rs  = sb[0].rs;
        hold_dat = sb[0].dat;
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int         a;
    int         k;
    logic [8:0] ins;

    lcd_bus.LCD_start       = 1'b0;
    lcd_bus.LCD_instruction = 9'h000;
    hit_reset();
    #1;
    check_reset_outputs("reset_state");
    repeat (3) step();
    Reset = 1'b0;

    // Idle stability
    repeat (1000) step();

    // Data write plus the clear, home and delay-selection boundary cases
    send(9'h157, 1); wait_idle();
    send(9'h001, 1); wait_idle();
    send(9'h003, 1); wait_idle();
    send(9'h103, 1); wait_idle();
    send(9'h002, 1); wait_idle();
    send(9'h000, 1); wait_idle();
    send(9'h004, 1); wait_idle();
    send(9'h100, 1); wait_idle();

    // Start while busy is dropped
    a = cyc + 1;
    send(9'h080, 1);
    while (cyc < a + 9) step();
    send(9'h0C0, 1);
    wait_idle();

    // Back-to-back: a start during the done cycle is accepted
    send(9'h080, 1);
    k = 0;
    while (cyc < last_done && k < 1000) begin step(); k++; end
    chk("b2b_align", cyc, last_done);
    send(9'h0C0, 1);
    wait_idle();

    // A start held for several cycles counts as one request
    send(9'h1A5, 5);
    wait_idle();

    // Reset in the middle of the EN pulse
    a = cyc + 1;
    send(9'h157, 1);
    while (cyc < a + 8) step();
    chk("pre_reset_en", lcd_bus.LCD_enable, 1);
    hit_reset();
    #1;
    check_reset_outputs("mid_reset");
    step();
    step();
    Reset = 1'b0;
    step();
    chk("power_after_release", lcd_bus.LCD_power, 1);
    send(9'h157, 1);
    wait_idle();

    // Random traffic, including starts that land while busy
    for (int i = 0; i < 30; i++) begin
      ins = 9'($urandom);
      if ($urandom_range(0, 3) == 0) ins = {7'd0, 2'($urandom_range(0, 3))};
      send(ins, $urandom_range(1, 3));
      repeat ($urandom_range(0, 60)) step();
    end
    wait_idle();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
